// File: rtl/seq_gen_prog.sv
// Programmable table-lookup sequence generator: index NOM walks a writable
// table between LO/HI bounds with wrap, saturate or ping-pong stepping.
module seq_gen_prog #(
    parameter int IDX_W = 4,
    parameter int DAT_W = 4,
    parameter int PER_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD,
    input  logic [IDX_W-1:0] DAT_I,
    input  logic             STEP,
    input  logic             UP,
    input  logic             RUN,
    input  logic [PER_W-1:0] PERIOD,
    input  logic [1:0]       MODE,
    input  logic [IDX_W-1:0] LO,
    input  logic [IDX_W-1:0] HI,
    input  logic             TWE,
    input  logic [IDX_W-1:0] TADDR,
    input  logic [DAT_W-1:0] TDATA,
    output logic [IDX_W-1:0] NOM,
    output logic [DAT_W-1:0] SEQ,
    output logic             STB,
    output logic             BND
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

    typedef enum logic [1:0] {
        MODE_WRAP  = 2'b00,
        MODE_SAT   = 2'b01,
        MODE_PING  = 2'b10,
        MODE_WRAP2 = 2'b11
    } mode_e;

    mode_e            mode;
    logic [DAT_W-1:0] tbl [DEPTH];
    logic [PER_W-1:0] div;
    logic             dir;
    logic             tick;
    logic             adv;
    logic             d;
    logic [IDX_W-1:0] hi_eff;
    logic [IDX_W-1:0] nom_nxt;
    logic             dir_nxt;
    logic             stb_nxt;
    logic             bnd_nxt;
    logic [DAT_W-1:0] seq_nxt;

    assign mode   = mode_e'(MODE);
    assign tick   = RUN && !LOAD && (div == PERIOD);
    assign adv    = STEP | tick;
    // An inverted window collapses onto LO.
    assign hi_eff = (LO > HI) ? LO : HI;

    // NOTE: combinational blocks assign every output a default first so no
    // path through the case/if tree can infer a latch.
    always_comb begin
        nom_nxt = NOM;
        dir_nxt = dir;
        stb_nxt = 1'b0;
        bnd_nxt = 1'b0;
        d       = (mode == MODE_PING) ? dir : UP;
        if (LOAD) begin
            nom_nxt = DAT_I;
            dir_nxt = UP;
            stb_nxt = 1'b1;
        end else if (adv) begin
            stb_nxt = 1'b1;
            if (LO == hi_eff) begin
                nom_nxt = LO;
                bnd_nxt = 1'b1;
            end else begin
                case (mode)
                    MODE_SAT: begin
                        if (d && NOM >= hi_eff) begin
                            nom_nxt = hi_eff;
                            bnd_nxt = 1'b1;
                        end else if (!d && NOM <= LO) begin
                            nom_nxt = LO;
                            bnd_nxt = 1'b1;
                        end else begin
                            nom_nxt = d ? NOM + IDX_ONE : NOM - IDX_ONE;
                        end
                    end
                    MODE_PING: begin
                        // Reversal steps off the endpoint so it is not emitted twice.
                        if (d && NOM >= hi_eff) begin
                            nom_nxt = hi_eff - IDX_ONE;
                            dir_nxt = 1'b0;
                            bnd_nxt = 1'b1;
                        end else if (!d && NOM <= LO) begin
                            nom_nxt = LO + IDX_ONE;
                            dir_nxt = 1'b1;
                            bnd_nxt = 1'b1;
                        end else begin
                            nom_nxt = d ? NOM + IDX_ONE : NOM - IDX_ONE;
                        end
                    end
                    default: begin
                        if (d && NOM >= hi_eff) begin
                            nom_nxt = LO;
                            bnd_nxt = 1'b1;
                        end else if (!d && NOM <= LO) begin
                            nom_nxt = hi_eff;
                            bnd_nxt = 1'b1;
                        end else begin
                            nom_nxt = d ? NOM + IDX_ONE : NOM - IDX_ONE;
                        end
                    end
                endcase
            end
        end
        // Write-first bypass keeps SEQ coherent with the table on the same edge.
        seq_nxt = (TWE && TADDR == nom_nxt) ? TDATA : tbl[nom_nxt];
    end

    // NOTE: the table is reset on purpose -- it must come back as the identity
    // map, so it is a register array rather than an inferred RAM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= DAT_W'(i);
            end
        end else if (TWE) begin
            tbl[TADDR] <= TDATA;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div <= '0;
            dir <= 1'b1;
            NOM <= '0;
            SEQ <= '0;
            STB <= 1'b0;
            BND <= 1'b0;
        end else begin
            if (!RUN || LOAD || tick) begin
                div <= '0;
            end else begin
                div <= div + PER_ONE;
            end
            dir <= dir_nxt;
            NOM <= nom_nxt;
            SEQ <= seq_nxt;
            STB <= stb_nxt;
            BND <= bnd_nxt;
        end
    end

endmodule

// File: tb/tb_seq_gen_prog.sv
// Directed self-checking bench for seq_gen_prog: reset, wrap, saturate,
// ping-pong, auto-run divider, table write-first and async reset.
module tb_seq_gen_prog;

    localparam int IDX_W = 4;
    localparam int DAT_W = 4;
    localparam int PER_W = 8;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             LOAD;
    logic [IDX_W-1:0] DAT_I;
    logic             STEP;
    logic             UP;
    logic             RUN;
    logic [PER_W-1:0] PERIOD;
    logic [1:0]       MODE;
    logic [IDX_W-1:0] LO;
    logic [IDX_W-1:0] HI;
    logic             TWE;
    logic [IDX_W-1:0] TADDR;
    logic [DAT_W-1:0] TDATA;
    logic [IDX_W-1:0] NOM;
    logic [DAT_W-1:0] SEQ;
    logic             STB;
    logic             BND;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    seq_gen_prog #(.IDX_W(IDX_W), .DAT_W(DAT_W), .PER_W(PER_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .DAT_I(DAT_I), .STEP(STEP),
        .UP(UP), .RUN(RUN), .PERIOD(PERIOD), .MODE(MODE), .LO(LO), .HI(HI),
        .TWE(TWE), .TADDR(TADDR), .TDATA(TDATA),
        .NOM(NOM), .SEQ(SEQ), .STB(STB), .BND(BND)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int nom, input int seq,
                              input logic stb, input logic bnd);
        chk({tag, ".nom"}, 32'(NOM), 32'(nom));
        chk({tag, ".seq"}, 32'(SEQ), 32'(seq));
        chk({tag, ".stb"}, 32'(STB), 32'(stb));
        chk({tag, ".bnd"}, 32'(BND), 32'(bnd));
    endtask

    task automatic do_step(input string tag, input int nom, input int seq, input logic bnd);
        STEP = 1'b1;
        cyc();
        STEP = 1'b0;
        expect_out(tag, nom, seq, 1'b1, bnd);
    endtask

    task automatic do_load(input string tag, input int idx, input int seq);
        LOAD  = 1'b1;
        DAT_I = IDX_W'(idx);
        cyc();
        LOAD  = 1'b0;
        expect_out(tag, idx, seq, 1'b1, 1'b0);
    endtask

    task automatic wait_tick(input string tag, input int nom);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk({tag, ".quiet"}, 32'(STB), 32'd0);
        end
        cyc();
        chk({tag, ".stb"}, 32'(STB), 32'd1);
        chk({tag, ".nom"}, 32'(NOM), 32'(nom));
    endtask

    initial begin
        RST_N = 1'b0; LOAD = 1'b0; DAT_I = '0; STEP = 1'b0; UP = 1'b1;
        RUN = 1'b0; PERIOD = '0; MODE = 2'b00; LO = '0; HI = 4'd15;
        TWE = 1'b0; TADDR = '0; TDATA = '0;
        #2;
        expect_out("reset", 0, 0, 1'b0, 1'b0);
        cyc();
        RST_N = 1'b1;
        cyc();
        expect_out("idle", 0, 0, 1'b0, 1'b0);

        // Wrap up through the full range
        for (int i = 1; i <= 17; i++) begin
            do_step($sformatf("wrap%0d", i), i % 16, i % 16, i == 16);
        end

        // Saturate down, then out-of-window load pulled to HI
        MODE = 2'b01; LO = 4'd3; HI = 4'd6; UP = 1'b0;
        do_load("sat.load", 5, 5);
        do_step("sat1", 4, 4, 1'b0);
        do_step("sat2", 3, 3, 1'b0);
        do_step("sat3", 3, 3, 1'b1);
        do_step("sat4", 3, 3, 1'b1);
        do_load("sat.load9", 9, 9);
        UP = 1'b1;
        do_step("sat.up", 6, 6, 1'b1);

        // Ping-pong
        MODE = 2'b10; LO = 4'd2; HI = 4'd4; UP = 1'b1;
        do_load("pp.load", 2, 2);
        do_step("pp1", 3, 3, 1'b0);
        do_step("pp2", 4, 4, 1'b0);
        do_step("pp3", 3, 3, 1'b1);
        do_step("pp4", 2, 2, 1'b0);
        do_step("pp5", 3, 3, 1'b1);
        do_step("pp6", 4, 4, 1'b0);

        // MODE 11 behaves as wrap; downward wrap LO -> HI
        MODE = 2'b11; LO = 4'd2; HI = 4'd5; UP = 1'b0;
        do_load("m3.load", 2, 2);
        do_step("m3.wrap", 5, 5, 1'b1);
        do_step("m3.dec", 4, 4, 1'b0);

        // LO > HI collapses to LO
        MODE = 2'b00; LO = 4'd9; HI = 4'd4; UP = 1'b1;
        do_step("inv1", 9, 9, 1'b1);
        do_step("inv2", 9, 9, 1'b1);

        // Auto-run divider with PERIOD=3
        LO = 4'd0; HI = 4'd15;
        do_load("run.load", 0, 0);
        RUN = 1'b1; PERIOD = 8'd3;
        wait_tick("run.t1", 1);
        wait_tick("run.t2", 2);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("run.pre", 32'(STB), 32'd0);
        end
        STEP = 1'b1;
        cyc();
        STEP = 1'b0;
        chk("run.coinc.nom", 32'(NOM), 32'd3);
        chk("run.coinc.stb", 32'(STB), 32'd1);
        cyc();
        chk("run.after", 32'(STB), 32'd0);
        do_load("run.reload", 8, 8);
        wait_tick("run.phase", 9);
        RUN = 1'b0;

        // Table write-first alongside LOAD, then write to held NOM
        TWE = 1'b1; TADDR = 4'd5; TDATA = 4'hA;
        do_load("tw.load", 5, 4'hA);
        TADDR = 4'd5; TDATA = 4'h3;
        cyc();
        TWE = 1'b0;
        expect_out("tw.hold", 5, 4'h3, 1'b0, 1'b0);
        TWE = 1'b1; TADDR = 4'd7; TDATA = 4'hC;
        cyc();
        TWE = 1'b0;
        expect_out("tw.other", 5, 4'h3, 1'b0, 1'b0);
        do_load("tw.read7", 7, 4'hC);

        // Async reset mid-run
        RUN = 1'b1; PERIOD = 8'd0;
        cyc();
        chk("ar.run1", 32'(NOM), 32'd8);
        cyc();
        chk("ar.run2", 32'(NOM), 32'd9);
        #3;
        RST_N = 1'b0;
        #1;
        expect_out("ar.async", 0, 0, 1'b0, 1'b0);
        cyc();
        cyc();
        expect_out("ar.held", 0, 0, 1'b0, 1'b0);
        RUN = 1'b0;
        RST_N = 1'b1;
        do_load("ar.id5", 5, 5);
        do_load("ar.id7", 7, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
